pipelined_barrel_shifter: RTL and testbench

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

---
 rtl/pipelined_barrel_shifter.sv | 111 +++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROR) with a capture stage followed by one
// shift stage per ShiftAmt bit; a stalled output freezes the whole pipeline.
module pipelined_barrel_shifter #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   Operand,
    input  logic [SHAMT_W-1:0] ShiftAmt,
    input  logic [1:0]         Mode,
    input  logic               InValid,
    output logic               InReady,
    output logic [WIDTH-1:0]   Result,
    output logic               Carry,
    output logic               OutValid,
    input  logic               OutReady
);

    localparam int unsigned L = SHAMT_W;

    typedef enum logic [1:0] {
        MODE_LSL = 2'b00,
        MODE_LSR = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    typedef struct packed {
        logic               valid;
        logic               carry;
        mode_e              mode;
        logic [SHAMT_W-1:0] shamt;
        logic [WIDTH-1:0]   data;
    } stage_t;

    // stg_q[0] holds the captured operation; stg_q[k+1] has shift bit k applied
    stage_t stg_q [L+1];
    stage_t stg_d [L+1];
    logic   stall;

    // Apply a shift of 2^k when bit k of the shift amount is set. The carry is the
    // last bit to leave, so each shifting stage overwrites the running carry.
    function automatic stage_t shift_step(input stage_t s, input int unsigned k);
        stage_t             r;
        logic [SHAMT_W-1:0] sel;
        logic [WIDTH-1:0]   rt;
        logic [WIDTH-1:0]   lf;
        int unsigned        sh;
        r   = s;
        sh  = 32'd1 << k;
        sel = s.shamt >> k;
        rt  = s.data >> (sh - 32'd1);
        lf  = s.data << (sh - 32'd1);
        if (s.valid && sel[0]) begin
            case (s.mode)
                MODE_LSL: begin
                    r.data  = s.data << sh;
                    r.carry = lf[WIDTH-1];
                end
                MODE_LSR: begin
                    r.data  = s.data >> sh;
                    r.carry = rt[0];
                end
                MODE_ASR: begin
                    r.data  = $signed(s.data) >>> sh;
                    r.carry = rt[0];
                end
                MODE_ROR: begin
                    r.data  = (s.data >> sh) | (s.data << (WIDTH - sh));
                    r.carry = rt[0];
                end
            endcase
        end
        return r;
    endfunction

    assign stall   = stg_q[L].valid && !OutReady;
    assign InReady = !stall;

    // Bubbles enter as all-zero stages so Result/Carry read 0 whenever not valid
    always_comb begin
        stg_d[0] = '0;
        if (InValid) begin
            stg_d[0].valid = 1'b1;
            stg_d[0].mode  = mode_e'(Mode);
            stg_d[0].shamt = ShiftAmt;
            stg_d[0].data  = Operand;
        end
        for (int unsigned k = 0; k < L; k++) begin
            stg_d[k+1] = shift_step(stg_q[k], k);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k <= L; k++) begin
                stg_q[k] <= '0;
            end
        end else if (!stall) begin
            for (int unsigned k = 0; k <= L; k++) begin
                stg_q[k] <= stg_d[k];
            end
        end
    end

    assign Result   = stg_q[L].data;
    assign Carry    = stg_q[L].carry;
    assign OutValid = stg_q[L].valid;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter at WIDTH=16: directed vectors,
// output back-pressure patterns and a mid-stream reset.
module tb_pipelined_barrel_shifter;

    localparam int unsigned W   = 16;
    localparam int unsigned SW  = 4;
    localparam int          LAT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  Operand;
    logic [SW-1:0] ShiftAmt;
    logic [1:0]    Mode;
    logic          InValid;
    logic          InReady;
    logic [W-1:0]  Result;
    logic          Carry;
    logic          OutValid;
    logic          OutReady;

    pipelined_barrel_shifter #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk      (clk),
        .reset    (reset),
        .Operand  (Operand),
        .ShiftAmt (ShiftAmt),
        .Mode     (Mode),
        .InValid  (InValid),
        .InReady  (InReady),
        .Result   (Result),
        .Carry    (Carry),
        .OutValid (OutValid),
        .OutReady (OutReady)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  op;
        logic [SW-1:0] n;
        logic [1:0]    mode;
        logic [W-1:0]  res;
        logic          c;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        int           acc;
        bit           lat;
    } exp_t;

    vec_t vecs [18];
    exp_t sb [$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   stall_seen = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_res   = '0;
    logic         prev_c     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer, checks stall behaviour
    always @(negedge clk) begin
        exp_t e;
        if (OutValid) begin
            check("inready_vs_stall", 32'(InReady), 32'(OutReady));
            if (!OutReady) stall_seen++;
            if (prev_stall) begin
                check("held_result", 32'(Result), 32'(prev_res));
                check("held_carry", 32'(Carry), 32'(prev_c));
            end
            if (OutReady) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(Result), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("result", 32'(Result), 32'(e.res));
                    check("carry", 32'(Carry), 32'(e.c));
                    if (e.lat) check("latency", 32'(cyc - e.acc), 32'(LAT));
                end
            end
        end else begin
            check("idle_result_zero", 32'(Result), 32'd0);
            check("idle_carry_zero", 32'(Carry), 32'd0);
            check("idle_inready", 32'(InReady), 32'd1);
        end
        prev_stall = OutValid && !OutReady;
        prev_res   = Result;
        prev_c     = Carry;
    end

    // Called just after a posedge; returns just after the posedge that accepted it
    task automatic send(input int i, input bit lat);
        bit done = 1'b0;
        Operand  = vecs[i].op;
        ShiftAmt = vecs[i].n;
        Mode     = vecs[i].mode;
        InValid  = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (InReady) begin
                sb.push_back('{res: vecs[i].res, c: vecs[i].c, acc: cyc + 1, lat: lat});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        InValid = 1'b0;
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge clk);
        check("drain_pending", 32'(sb.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] pat;
        pat = 16'b1011_0010_1110_0101;
        //            op        n  mode  result   carry
        vecs[0]  = '{16'h8001, 1,  0, 16'h0002, 1'b1};
        vecs[1]  = '{16'h8F00, 4,  2, 16'hF8F0, 1'b0};
        vecs[2]  = '{16'h8000, 15, 1, 16'h0001, 1'b0};
        vecs[3]  = '{16'h1234, 4,  3, 16'h4123, 1'b0};
        vecs[4]  = '{16'h000F, 4,  3, 16'hF000, 1'b1};
        vecs[5]  = '{16'hABCD, 0,  0, 16'hABCD, 1'b0};
        vecs[6]  = '{16'hABCD, 0,  1, 16'hABCD, 1'b0};
        vecs[7]  = '{16'hABCD, 0,  2, 16'hABCD, 1'b0};
        vecs[8]  = '{16'hABCD, 0,  3, 16'hABCD, 1'b0};
        vecs[9]  = '{16'h00F0, 12, 0, 16'h0000, 1'b1};
        vecs[10] = '{16'h4000, 15, 2, 16'h0000, 1'b1};
        vecs[11] = '{16'h8000, 15, 2, 16'hFFFF, 1'b0};
        vecs[12] = '{16'h0001, 1,  3, 16'h8000, 1'b1};
        vecs[13] = '{16'h8421, 15, 3, 16'h0843, 1'b0};
        vecs[14] = '{16'hFFFF, 8,  1, 16'h00FF, 1'b1};
        vecs[15] = '{16'h1234, 4,  0, 16'h2340, 1'b1};
        vecs[16] = '{16'h8765, 7,  2, 16'hFF0E, 1'b1};
        vecs[17] = '{16'h5A5A, 3,  1, 16'h0B4B, 1'b0};

        reset    = 1'b1;
        Operand  = '0;
        ShiftAmt = '0;
        Mode     = '0;
        InValid  = 1'b0;
        OutReady = 1'b1;
        #1;
        check("rst_outvalid", 32'(OutValid), 32'd0);
        check("rst_result", 32'(Result), 32'd0);
        check("rst_carry", 32'(Carry), 32'd0);
        check("rst_inready", 32'(InReady), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Isolated first operation, then the full table back to back
        send(0, 1'b1);
        drain();
        for (int i = 1; i < 18; i++) send(i, 1'b1);
        drain();

        // Six back-to-back with OutReady low for three cycles mid-stream
        stall_seen = 0;
        fork
            for (int i = 0; i < 6; i++) send(i, 1'b0);
            begin
                repeat (5) @(posedge clk);
                #1 OutReady = 1'b0;
                repeat (3) @(posedge clk);
                #1 OutReady = 1'b1;
            end
        join
        drain();
        check("stall_observed", 32'(stall_seen > 0), 32'd1);

        // Irregular back-pressure across the rest of the table
        fork
            for (int i = 6; i < 18; i++) send(i, 1'b0);
            begin
                for (int t = 0; t < 40; t++) begin
                    @(posedge clk);
                    #1 OutReady = pat[t % 16];
                end
                OutReady = 1'b1;
            end
        join
        OutReady = 1'b1;
        drain();

        // Reset with the pipeline full; nothing in flight may emerge afterwards
        for (int i = 9; i < 14; i++) send(i, 1'b0);
        check("pre_reset_outvalid", 32'(OutValid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_outvalid", 32'(OutValid), 32'd0);
        check("mid_rst_result", 32'(Result), 32'd0);
        check("mid_rst_carry", 32'(Carry), 32'd0);
        check("mid_rst_inready", 32'(InReady), 32'd1);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        send(3, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
